dram_w_responder: RTL and testbench
===================================

DRAM_W_RESPONDER -- requirements
Module: dram_w_responder

Interface
REQ-001 Parameter DATA_W, default 64, W data width in bits.
REQ-002 Parameter ID_W, default 4, transaction ID width.
REQ-003 Parameter STRB_W, default 4, W strobe width; each strobe bit qualifies DATA_W/STRB_W (16) data bits.
REQ-004 Parameter ADDR_W, default 8, memory word-address width.
REQ-005 Port clk  input  1  single clock; all logic on the rising edge.
REQ-006 Port rst_n  input  1  synchronous reset, active-high: 1 = reset.
REQ-007 Ports aw_valid input 1, aw_ready output 1, aw_id input ID_W, aw_addr input ADDR_W, aw_len input 4: burst header, beats = aw_len+1.
REQ-008 Ports w_id input ID_W, w_data input DATA_W, w_strb input STRB_W, w_last input 1, w_valid input 1: W beat from the on-chip initiator.
REQ-009 Port w_ready  output  1  responder accepts a W beat.
REQ-010 Ports mem_we output 1, mem_addr output ADDR_W, mem_wdata output DATA_W, mem_wmask output DATA_W: registered memory write port.
REQ-011 Ports b_valid output 1, b_ready input 1, b_id output ID_W, b_resp output 2: write response.

Function
REQ-012 A handshake occurs on a channel in a cycle where valid and ready are both 1 at the clock edge.
REQ-013 The FSM has states IDLE, DATA and RESP; aw_ready = (state==IDLE) and w_ready = (state==DATA), both decoded from registered state.
REQ-014 IDLE: an AW handshake latches aw_id, aw_addr and aw_len, clears beat count and error flag, and moves to DATA.
REQ-015 DATA: each W handshake increments the beat count; the block writes only when the beat count is at most the latched aw_len.
REQ-016 A beat that writes drives mem_we=1 in the cycle after the handshake, with mem_addr = latched base + beat index mod 2^ADDR_W, mem_wdata = w_data, and mem_wmask bit i = w_strb[i/16].
REQ-017 An address that passes 2^ADDR_W-1 wraps to 0.
REQ-018 mem_we is 0 in every cycle that does not follow a writing W handshake.
REQ-019 Error conditions: w_id != latched aw_id sets the error flag, but the beat is still written.
REQ-020 Error conditions: w_last=1 on beat index < aw_len (early last) sets the error flag.
REQ-021 Error conditions: beat index == aw_len with w_last=0 sets the error flag.
REQ-022 Error conditions: beats after index aw_len are accepted with no write until w_last=1.
REQ-023 A W handshake with w_last=1 moves DATA to RESP; b_valid=1 from the next cycle.
REQ-024 In RESP, b_id = latched ID and b_resp = 2'b10 (SLVERR) if the error flag is set, else 2'b00 (OKAY).
REQ-025 In RESP, b_valid, b_id and b_resp hold stable until b_ready=1.
REQ-026 A B handshake returns the FSM to IDLE; the next AW is accepted no earlier than the cycle after.
REQ-027 w_valid in IDLE or RESP is ignored (w_ready=0), and aw_valid in DATA or RESP is ignored.
REQ-028 Back-to-back beats sustain 1 beat/cycle.
REQ-029 Minimum burst-to-burst turnaround is AW(1) + beats + RESP(1).

Reset
REQ-030 While rst_n=1 at a clock edge, the next state is IDLE and every register clears.
REQ-031 Outputs after reset: aw_ready=1, w_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0, b_valid=0, b_id=0, b_resp=0.
REQ-032 A reset during DATA or RESP abandons the burst with no B response, and a pending mem_we is cleared in the same edge.

Structure
REQ-033 A shared package holds the FSM state enum, the parameter defaults, and the response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
REQ-034 The strobe-to-bitmask expansion is a sub-module named strb_expand (STRB_W in, DATA_W out, combinational); all other logic is in dram_w_responder.

Verification
REQ-035 AW id=3, addr=0x10, len=3; 4 beats, data 0xA0..0xA3, strb 4'hF, last on beat 3 -> mem writes at 0x10..0x13 with mask all-ones, then b_id=3, b_resp=OKAY.
REQ-036 AW addr=0xFE, len=3 -> writes at 0xFE, 0xFF, 0x00, 0x01.
REQ-037 A beat with strb 4'b0101 -> mem_wmask = 64'h0000_FFFF_0000_FFFF.
REQ-038 AW len=3 with last on beat 1 -> 2 writes, b_resp=SLVERR.
REQ-039 AW len=3 with last on beat 1, alternate case: AW len=1 with last on beat 3 -> 2 writes, 4 beats accepted, b_resp=SLVERR.
REQ-040 AW id=5 with w_id=6 on one beat -> all beats written, b_id=5, b_resp=SLVERR.
REQ-041 b_ready held 0 for 5 cycles -> b_valid, b_id and b_resp stable and aw_ready=0 throughout.
REQ-042 rst_n pulsed mid-DATA -> next cycle aw_ready=1, mem_we=0, b_valid=0, and a new burst completes normally.

Source files
------------

// File: rtl/dram_w_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dram_w_responder_pkg
//  Purpose  : Shared types and constants for the DRAM write responder:
//             FSM state encoding, parameter defaults and B response codes.
//  Revision : 1.0  initial release
// ============================================================================
package dram_w_responder_pkg;

   localparam int DATA_W_DEF = 64;
   localparam int ID_W_DEF   = 4;
   localparam int STRB_W_DEF = 4;
   localparam int ADDR_W_DEF = 8;
   localparam int LEN_W      = 4;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/strb_expand.sv
`default_nettype none
// ============================================================================
//  Module   : strb_expand
//  Purpose  : Combinational expansion of a byte-lane style strobe into a
//             per-bit write mask. Each strobe bit covers DATA_W/STRB_W bits.
//  Ports    : i_strb [STRB_W] strobe in
//             o_mask [DATA_W] bit mask out
//  Revision : 1.0  initial release
// ============================================================================
module strb_expand #(
   parameter int STRB_W = 4,
   parameter int DATA_W = 64
) (
   input  logic [STRB_W-1:0] i_strb,
   output logic [DATA_W-1:0] o_mask
);

   localparam int LANE_W = DATA_W / STRB_W;

   for (genvar i = 0; i < STRB_W; i++) begin : g_lane
      assign o_mask[i*LANE_W +: LANE_W] = {LANE_W{i_strb[i]}};
   end

endmodule
`default_nettype wire

// File: rtl/dram_w_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dram_w_responder
//  Purpose  : Accepts one AW burst header, writes the W beats of that burst
//             into a word-addressed memory port (one registered write per
//             beat), then returns a single B response (OKAY or SLVERR).
//  Ports    : clk, rst_n (synchronous, active-high reset)
//             aw_*  burst header channel (id, word address, len = beats-1)
//             w_*   write data channel
//             mem_* registered memory write port
//             b_*   write response channel
//  Revision : 1.0  initial release
// ============================================================================
module dram_w_responder
   import dram_w_responder_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ID_W   = ID_W_DEF,
   parameter int STRB_W = STRB_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              aw_valid,
   output logic              aw_ready,
   input  logic [ID_W-1:0]   aw_id,
   input  logic [ADDR_W-1:0] aw_addr,
   input  logic [LEN_W-1:0]  aw_len,
   input  logic [ID_W-1:0]   w_id,
   input  logic [DATA_W-1:0] w_data,
   input  logic [STRB_W-1:0] w_strb,
   input  logic              w_last,
   input  logic              w_valid,
   output logic              w_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_wmask,
   output logic              b_valid,
   input  logic              b_ready,
   output logic [ID_W-1:0]   b_id,
   output logic [1:0]        b_resp
);

   // One extra bit so the beat counter can sit above any legal len and
   // saturate there: once past the burst it never wraps back into range.
   localparam logic [LEN_W:0] CNT_SAT = {1'b1, {LEN_W{1'b0}}};

   state_t              r_state;
   logic [ID_W-1:0]     r_id;
   logic [ADDR_W-1:0]   r_base;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W:0]      r_cnt;
   logic                r_err;

   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [DATA_W-1:0]   r_mem_wmask;
   logic                r_b_valid;
   logic [ID_W-1:0]     r_b_id;
   logic [1:0]          r_b_resp;

   logic [DATA_W-1:0]   w_mask;
   logic                w_in_burst;
   logic                w_beat_err;
   logic [ADDR_W-1:0]   w_beat_addr;

   strb_expand #(
      .STRB_W (STRB_W),
      .DATA_W (DATA_W)
   ) u_strb_expand (
      .i_strb (w_strb),
      .o_mask (w_mask)
   );

   assign w_in_burst  = (r_cnt <= {1'b0, r_len});
   assign w_beat_addr = r_base + ADDR_W'(r_cnt[LEN_W-1:0]);

   // Any of: wrong ID, last too early, or missing last on the final beat.
   assign w_beat_err  = (w_id != r_id)
                      | (w_last  & (r_cnt <  {1'b0, r_len}))
                      | (~w_last & (r_cnt == {1'b0, r_len}));

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state     <= ST_IDLE;
         r_id        <= '0;
         r_base      <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_err       <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wmask <= '0;
         r_b_valid   <= 1'b0;
         r_b_id      <= '0;
         r_b_resp    <= RESP_OKAY;
      end else begin
         r_mem_we <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (aw_valid) begin
                  r_id    <= aw_id;
                  r_base  <= aw_addr;
                  r_len   <= aw_len;
                  r_cnt   <= '0;
                  r_err   <= 1'b0;
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_valid) begin
                  // Beats beyond len are consumed but never written.
                  if (w_in_burst) begin
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= w_beat_addr;
                     r_mem_wdata <= w_data;
                     r_mem_wmask <= w_mask;
                  end
                  if (r_cnt != CNT_SAT) begin
                     r_cnt <= r_cnt + 1'b1;
                  end
                  if (w_beat_err) begin
                     r_err <= 1'b1;
                  end
                  if (w_last) begin
                     r_state   <= ST_RESP;
                     r_b_valid <= 1'b1;
                     r_b_id    <= r_id;
                     r_b_resp  <= (r_err | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                  end
               end
            end
            ST_RESP: begin
               if (b_ready) begin
                  r_b_valid <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign aw_ready  = (r_state == ST_IDLE);
   assign w_ready   = (r_state == ST_DATA);
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_wmask = r_mem_wmask;
   assign b_valid   = r_b_valid;
   assign b_id      = r_b_id;
   assign b_resp    = r_b_resp;

endmodule
`default_nettype wire

// File: tb/tb_dram_w_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dram_w_responder
//  Purpose  : Self-checking bench for dram_w_responder. A burst-level model
//             predicts every output each cycle; directed bursts pin the model
//             with literal expectations, then randomized bursts follow.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dram_w_responder;

   logic        clk;
   logic        rst_n;
   logic        aw_valid;
   logic        aw_ready;
   logic [3:0]  aw_id;
   logic [7:0]  aw_addr;
   logic [3:0]  aw_len;
   logic [3:0]  w_id;
   logic [63:0] w_data;
   logic [3:0]  w_strb;
   logic        w_last;
   logic        w_valid;
   logic        w_ready;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_wmask;
   logic        b_valid;
   logic        b_ready;
   logic [3:0]  b_id;
   logic [1:0]  b_resp;

   int n_checks = 0;
   int n_errors = 0;

   dram_w_responder #(
      .DATA_W (64),
      .ID_W   (4),
      .STRB_W (4),
      .ADDR_W (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .aw_valid  (aw_valid),
      .aw_ready  (aw_ready),
      .aw_id     (aw_id),
      .aw_addr   (aw_addr),
      .aw_len    (aw_len),
      .w_id      (w_id),
      .w_data    (w_data),
      .w_strb    (w_strb),
      .w_last    (w_last),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wmask (mem_wmask),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .b_id      (b_id),
      .b_resp    (b_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: timeout waiting for DUT", name);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "timeout");
   endtask

   function automatic logic [63:0] expand(input logic [3:0] s);
      logic [63:0] m;
      for (int i = 0; i < 64; i++) m[i] = s[i / 16];
      return m;
   endfunction

   // ---------------- burst-level reference model ----------------
   // phase 0 = waiting for header, 1 = taking beats, 2 = response pending
   int          m_phase = 0;
   int          m_base, m_len, m_idx;
   logic [3:0]  m_id;
   bit          m_err;
   bit          model_ok = 0;
   bit          e_we = 0;
   bit          e_after_rst = 0;
   logic [7:0]  e_addr;
   logic [63:0] e_data, e_mask;
   logic [3:0]  e_bid;
   logic [1:0]  e_bresp;

   always @(posedge clk) begin
      e_we        = 0;
      e_after_rst = 0;
      if (rst_n) begin
         m_phase     = 0;
         e_after_rst = 1;
         model_ok    = 1;
      end else begin
         case (m_phase)
            0: if (aw_valid) begin
                  m_id = aw_id; m_base = int'(aw_addr); m_len = int'(aw_len);
                  m_idx = 0; m_err = 0; m_phase = 1;
               end
            1: if (w_valid) begin
                  if (m_idx <= m_len) begin
                     e_we   = 1;
                     e_addr = 8'((m_base + m_idx) % 256);
                     e_data = w_data;
                     e_mask = expand(w_strb);
                  end
                  if (w_id != m_id) m_err = 1;
                  if (w_last && m_idx < m_len) m_err = 1;
                  if (!w_last && m_idx == m_len) m_err = 1;
                  m_idx++;
                  if (w_last) begin
                     m_phase = 2;
                     e_bid   = m_id;
                     e_bresp = m_err ? 2'b10 : 2'b00;
                  end
               end
            default: if (b_ready) m_phase = 0;
         endcase
      end
   end

   typedef struct {
      logic [7:0]  a;
      logic [63:0] d;
      logic [63:0] m;
   } wr_t;
   wr_t        wr_log[$];
   logic [5:0] b_log[$];

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (model_ok) begin
         chk("aw_ready", 64'(aw_ready), 64'(m_phase == 0));
         chk("w_ready",  64'(w_ready),  64'(m_phase == 1));
         chk("b_valid",  64'(b_valid),  64'(m_phase == 2));
         chk("mem_we",   64'(mem_we),   64'(e_we));
         if (e_we) begin
            chk("mem_addr",  64'(mem_addr), 64'(e_addr));
            chk("mem_wdata", mem_wdata, e_data);
            chk("mem_wmask", mem_wmask, e_mask);
         end
         if (m_phase == 2) begin
            chk("b_id",   64'(b_id),   64'(e_bid));
            chk("b_resp", 64'(b_resp), 64'(e_bresp));
         end
         if (e_after_rst) begin
            chk("rst_mem_addr",  64'(mem_addr), 64'd0);
            chk("rst_mem_wdata", mem_wdata, 64'd0);
            chk("rst_mem_wmask", mem_wmask, 64'd0);
            chk("rst_b_id",      64'(b_id), 64'd0);
            chk("rst_b_resp",    64'(b_resp), 64'd0);
         end
         if (mem_we) wr_log.push_back('{a: mem_addr, d: mem_wdata, m: mem_wmask});
         if (b_valid && b_ready) b_log.push_back({b_id, b_resp});
      end
   end

   // ---------------- stimulus ----------------
   // strb < 0 selects a random strobe per beat; dbase == 0 selects random data.
   task automatic burst(input logic [3:0] id, input logic [7:0] addr, input logic [3:0] len,
                        input int nbeats, input int bad_beat, input int strb,
                        input logic [63:0] dbase, input int bwait, input bit gaps);
      int n;
      @(posedge clk); #1;
      aw_valid = 1'b1; aw_id = id; aw_addr = addr; aw_len = len;
      // junk W traffic while idle must be ignored
      w_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      w_last  = 1'($urandom_range(0, 1));
      w_id    = 4'($urandom);
      n = 0;
      @(negedge clk);
      while (!aw_ready && n < 50) begin @(negedge clk); n++; end
      if (!aw_ready) timeout("aw_wait");
      @(posedge clk); #1;
      aw_valid = 1'b0;
      w_valid  = 1'b0;
      for (int k = 0; k < nbeats; k++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               w_valid  = 1'b0;
               aw_valid = 1'($urandom_range(0, 1));
               aw_id    = 4'($urandom);
               @(posedge clk); #1;
            end
         end
         aw_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
         w_valid  = 1'b1;
         w_id     = (k == bad_beat) ? id + 4'd1 : id;
         w_data   = (dbase == 64'd0) ? {$urandom, $urandom} : dbase + 64'(k);
         w_strb   = (strb < 0) ? 4'($urandom) : 4'(strb);
         w_last   = (k == nbeats - 1);
         n = 0;
         @(negedge clk);
         while (!w_ready && n < 50) begin @(negedge clk); n++; end
         if (!w_ready) timeout("w_wait");
         @(posedge clk); #1;
      end
      w_valid = 1'b0; w_last = 1'b0; aw_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!b_valid && n < 50) begin @(negedge clk); n++; end
      if (!b_valid) timeout("b_wait");
      repeat (bwait) begin
         w_valid = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      w_valid = 1'b0;
      b_ready = 1'b1;
      @(posedge clk); #1;
      b_ready = 1'b0;
   endtask

   task automatic chk_writes(input string tag, input int nexp, input logic [7:0] a0,
                             input logic [63:0] d0, input logic [63:0] mask);
      chk({tag, "_nwrites"}, 64'(wr_log.size()), 64'(nexp));
      for (int k = 0; k < nexp && k < wr_log.size(); k++) begin
         chk({tag, "_addr"}, 64'(wr_log[k].a), 64'(8'(a0 + 8'(k))));
         chk({tag, "_data"}, wr_log[k].d, d0 + 64'(k));
         chk({tag, "_mask"}, wr_log[k].m, mask);
      end
   endtask

   task automatic chk_b(input string tag, input logic [3:0] id, input logic [1:0] resp);
      chk({tag, "_nb"}, 64'(b_log.size()), 64'd1);
      if (b_log.size() > 0) begin
         chk({tag, "_bid"},   64'(b_log[0][5:2]), 64'(id));
         chk({tag, "_bresp"}, 64'(b_log[0][1:0]), 64'(resp));
      end
   endtask

   task automatic clear_logs();
      wr_log.delete();
      b_log.delete();
   endtask

   initial begin
      #3000000;
      $display("FAIL global_timeout: got running expected finished");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "global timeout");
   end

   initial begin
      rst_n = 1'b1; aw_valid = 1'b0; aw_id = '0; aw_addr = '0; aw_len = '0;
      w_id = '0; w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("init_aw_ready", 64'(aw_ready), 64'd1);
      chk("init_w_ready",  64'(w_ready),  64'd0);
      chk("init_mem_we",   64'(mem_we),   64'd0);
      chk("init_b_valid",  64'(b_valid),  64'd0);

      // basic 4-beat burst
      clear_logs();
      burst(4'd3, 8'h10, 4'd3, 4, -1, 15, 64'hA0, 0, 0);
      chk_writes("basic", 4, 8'h10, 64'hA0, {64{1'b1}});
      chk_b("basic", 4'd3, 2'b00);

      // address wrap
      clear_logs();
      burst(4'd1, 8'hFE, 4'd3, 4, -1, 15, 64'h100, 0, 0);
      chk_writes("wrap", 4, 8'hFE, 64'h100, {64{1'b1}});
      chk_b("wrap", 4'd1, 2'b00);

      // sparse strobe
      clear_logs();
      burst(4'd2, 8'h20, 4'd0, 1, -1, 5, 64'h55, 0, 0);
      chk_writes("strb", 1, 8'h20, 64'h55, 64'h0000_FFFF_0000_FFFF);
      chk_b("strb", 4'd2, 2'b00);

      // early last
      clear_logs();
      burst(4'd4, 8'h30, 4'd3, 2, -1, 15, 64'hB0, 0, 0);
      chk_writes("early", 2, 8'h30, 64'hB0, {64{1'b1}});
      chk_b("early", 4'd4, 2'b10);

      // late last: 4 beats on len=1
      clear_logs();
      burst(4'd4, 8'h38, 4'd1, 4, -1, 15, 64'hC0, 0, 0);
      chk_writes("late", 2, 8'h38, 64'hC0, {64{1'b1}});
      chk_b("late", 4'd4, 2'b10);

      // wrong W ID on one beat
      clear_logs();
      burst(4'd5, 8'h40, 4'd3, 4, 2, 15, 64'hD0, 0, 0);
      chk_writes("badid", 4, 8'h40, 64'hD0, {64{1'b1}});
      chk_b("badid", 4'd5, 2'b10);

      // B back-pressure for 5 cycles
      clear_logs();
      burst(4'd6, 8'h50, 4'd1, 2, -1, 15, 64'hE0, 5, 0);
      chk_writes("bstall", 2, 8'h50, 64'hE0, {64{1'b1}});
      chk_b("bstall", 4'd6, 2'b00);

      // reset pulse mid-DATA, coinciding with a W handshake
      clear_logs();
      @(posedge clk); #1;
      aw_valid = 1'b1; aw_id = 4'd7; aw_addr = 8'h60; aw_len = 4'd3;
      @(negedge clk);
      @(posedge clk); #1;
      aw_valid = 1'b0;
      w_valid = 1'b1; w_id = 4'd7; w_data = 64'h1; w_strb = 4'hF; w_last = 1'b0;
      @(posedge clk); #1;
      w_data = 64'h2;
      rst_n  = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0; w_valid = 1'b0;
      @(negedge clk);
      chk("rstmid_aw_ready", 64'(aw_ready), 64'd1);
      chk("rstmid_mem_we",   64'(mem_we),   64'd0);
      chk("rstmid_b_valid",  64'(b_valid),  64'd0);
      chk("rstmid_nb",       64'(b_log.size()), 64'd0);
      clear_logs();
      burst(4'd8, 8'h70, 4'd3, 4, -1, 15, 64'hF0, 1, 0);
      chk_writes("postrst", 4, 8'h70, 64'hF0, {64{1'b1}});
      chk_b("postrst", 4'd8, 2'b00);

      // randomized bursts, checked cycle by cycle against the model
      for (int t = 0; t < 60; t++) begin
         int len, nb, bad;
         len = int'($urandom_range(0, 15));
         case ($urandom_range(0, 3))
            0:       nb = int'($urandom_range(1, 18));
            default: nb = len + 1;
         endcase
         bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
         burst(4'($urandom), 8'($urandom), 4'(len), nb, bad, -1, 64'd0,
               int'($urandom_range(0, 3)), 1'b1);
      end

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
